// File: rtl/blackjack_shoe_dealer.sv
// -----------------------------------------------------------------------------
// blackjack_shoe_dealer
//   Models a shoe of N decks and deals cards from it without replacement.
//   Drives the same one-cycle event pulses the card-counter block consumes.
//   Cards are tracked per category only: small (2-6), seven (7-9), large (10-A).
//   Card selection is rejection sampling on an internal 16-bit Galois LFSR, so a
//   fixed SEED gives a reproducible deal sequence.
//
// Ports
//   clk        in   clock
//   rst        in   synchronous active-high reset
//   start      in   pulse: load a new shoe of num_decks decks (clamped to MAX_DECKS)
//   num_decks  in   [7:0] deck count, sampled on start
//   deal_req   in   level: request the next card (hold until the card pulse)
//   undo       in   pulse: return the last dealt card to the shoe
//   deck_add   out  one-cycle pulse per deck loaded
//   small_add  out  one-cycle pulse: small card dealt
//   seven_add  out  one-cycle pulse: seven card dealt
//   large_add  out  one-cycle pulse: large card dealt
//   back       out  one-cycle pulse: last card returned to the shoe
//   busy       out  loading decks or drawing a card
//   empty      out  shoe exhausted
//   remaining  out  [15:0] cards left in the shoe
// -----------------------------------------------------------------------------
module blackjack_shoe_dealer #(
    parameter int unsigned MAX_DECKS = 8,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  num_decks,
    input  logic        deal_req,
    input  logic        undo,
    output logic        deck_add,
    output logic        small_add,
    output logic        seven_add,
    output logic        large_add,
    output logic        back,
    output logic        busy,
    output logic        empty,
    output logic [15:0] remaining
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DEAL  = 3'd2,
        ST_DRAW  = 3'd3,
        ST_EMPTY = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        CAT_SMALL = 2'd0,
        CAT_SEVEN = 2'd1,
        CAT_LARGE = 2'd2
    } cat_t;

    // An all-zero LFSR would lock up, so a zero seed is replaced by 1.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [7:0]  MAX_EFF  = 8'(MAX_DECKS);

    // Galois right-shift step, taps 0xB400.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        lfsr_step = {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
    endfunction

    // (smallest power of two >= n) - 1, by smearing the top set bit of n-1 downwards.
    function automatic logic [15:0] pow2_mask(input logic [15:0] n);
        logic [15:0] m;
        m = n - 16'd1;
        m = m | (m >> 1);
        m = m | (m >> 2);
        m = m | (m >> 4);
        m = m | (m >> 8);
        pow2_mask = m;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] lfsr_r;
    logic [15:0] small_rem_r, small_rem_s;
    logic [15:0] seven_rem_r, seven_rem_s;
    logic [15:0] large_rem_r, large_rem_s;
    logic [7:0]  deck_cnt_r, deck_cnt_s;
    logic [3:0]  retry_r, retry_s;
    cat_t        last_cat_r, last_cat_s;
    logic        last_valid_r, last_valid_s;

    logic        deck_add_r, deck_add_s;
    logic        small_add_r, small_add_s;
    logic        seven_add_r, seven_add_s;
    logic        large_add_r, large_add_s;
    logic        back_r, back_s;
    logic        busy_r, busy_s;
    logic        empty_r, empty_s;
    logic [15:0] remaining_r, remaining_s;

    logic [7:0]  eff_s;
    logic [15:0] rem_s;
    logic [15:0] pick_s;
    logic        take_s;
    logic        give_back_s;
    cat_t        card_cat_s;

    assign eff_s  = (num_decks > MAX_EFF) ? MAX_EFF : num_decks;
    assign rem_s  = small_rem_r + seven_rem_r + large_rem_r;
    assign pick_s = lfsr_r & pow2_mask(rem_s);

    // Next-state, pool bookkeeping and next event pulses.
    always_comb begin
        state_s      = state_r;
        small_rem_s  = small_rem_r;
        seven_rem_s  = seven_rem_r;
        large_rem_s  = large_rem_r;
        deck_cnt_s   = deck_cnt_r;
        retry_s      = retry_r;
        last_cat_s   = last_cat_r;
        last_valid_s = last_valid_r;
        deck_add_s   = 1'b0;
        small_add_s  = 1'b0;
        seven_add_s  = 1'b0;
        large_add_s  = 1'b0;
        back_s       = 1'b0;
        take_s       = 1'b0;
        give_back_s  = 1'b0;
        card_cat_s   = CAT_SMALL;

        if (start) begin
            small_rem_s  = 16'(eff_s) * 16'd20;
            seven_rem_s  = 16'(eff_s) * 16'd12;
            large_rem_s  = 16'(eff_s) * 16'd20;
            deck_cnt_s   = eff_s;
            retry_s      = 4'd0;
            last_valid_s = 1'b0;
            if (eff_s == 8'd0) begin
                state_s = ST_EMPTY;
            end else begin
                state_s = ST_LOAD;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_s = ST_IDLE;
                end
                ST_LOAD: begin
                    deck_add_s = 1'b1;
                    deck_cnt_s = deck_cnt_r - 8'd1;
                    if (deck_cnt_r <= 8'd1) begin
                        state_s = ST_DEAL;
                    end else begin
                        state_s = ST_LOAD;
                    end
                end
                ST_DEAL: begin
                    // Undo outranks deal_req; the requester keeps deal_req held.
                    if (rem_s == 16'd0) begin
                        state_s = ST_EMPTY;
                    end else if (undo && last_valid_r) begin
                        give_back_s = 1'b1;
                    end else if (deal_req) begin
                        state_s = ST_DRAW;
                    end else begin
                        state_s = ST_DEAL;
                    end
                end
                ST_DRAW: begin
                    // Uniform pick over the remaining cards; after 15 misses in a row
                    // the pick is forced so latency stays bounded.
                    if (pick_s < rem_s) begin
                        take_s = 1'b1;
                        if (pick_s < small_rem_r) begin
                            card_cat_s = CAT_SMALL;
                        end else if (pick_s < (small_rem_r + seven_rem_r)) begin
                            card_cat_s = CAT_SEVEN;
                        end else begin
                            card_cat_s = CAT_LARGE;
                        end
                    end else if (retry_r == 4'd15) begin
                        take_s = 1'b1;
                        if (large_rem_r != 16'd0) begin
                            card_cat_s = CAT_LARGE;
                        end else if (seven_rem_r != 16'd0) begin
                            card_cat_s = CAT_SEVEN;
                        end else begin
                            card_cat_s = CAT_SMALL;
                        end
                    end else begin
                        retry_s = retry_r + 4'd1;
                    end
                end
                ST_EMPTY: begin
                    if (undo && last_valid_r) begin
                        give_back_s = 1'b1;
                        state_s     = ST_DEAL;
                    end else begin
                        state_s = ST_EMPTY;
                    end
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase

            if (give_back_s) begin
                back_s       = 1'b1;
                last_valid_s = 1'b0;
                case (last_cat_r)
                    CAT_SMALL: small_rem_s = small_rem_r + 16'd1;
                    CAT_SEVEN: seven_rem_s = seven_rem_r + 16'd1;
                    CAT_LARGE: large_rem_s = large_rem_r + 16'd1;
                    default:   small_rem_s = small_rem_r;
                endcase
            end else begin
                back_s = 1'b0;
            end

            if (take_s) begin
                state_s      = ST_DEAL;
                retry_s      = 4'd0;
                last_cat_s   = card_cat_s;
                last_valid_s = 1'b1;
                case (card_cat_s)
                    CAT_SMALL: begin
                        small_add_s = 1'b1;
                        small_rem_s = small_rem_r - 16'd1;
                    end
                    CAT_SEVEN: begin
                        seven_add_s = 1'b1;
                        seven_rem_s = seven_rem_r - 16'd1;
                    end
                    CAT_LARGE: begin
                        large_add_s = 1'b1;
                        large_rem_s = large_rem_r - 16'd1;
                    end
                    default: begin
                        small_add_s = 1'b0;
                    end
                endcase
            end else begin
                small_add_s = 1'b0;
            end
        end

        busy_s      = (state_s == ST_LOAD) || (state_s == ST_DRAW);
        empty_s     = (state_s == ST_EMPTY);
        remaining_s = small_rem_s + seven_rem_s + large_rem_s;
    end

    // State, pools, LFSR and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= SEED_EFF;
            small_rem_r  <= 16'd0;
            seven_rem_r  <= 16'd0;
            large_rem_r  <= 16'd0;
            deck_cnt_r   <= 8'd0;
            retry_r      <= 4'd0;
            last_cat_r   <= CAT_SMALL;
            last_valid_r <= 1'b0;
            deck_add_r   <= 1'b0;
            small_add_r  <= 1'b0;
            seven_add_r  <= 1'b0;
            large_add_r  <= 1'b0;
            back_r       <= 1'b0;
            busy_r       <= 1'b0;
            empty_r      <= 1'b0;
            remaining_r  <= 16'd0;
        end else begin
            state_r      <= state_s;
            lfsr_r       <= lfsr_step(lfsr_r);
            small_rem_r  <= small_rem_s;
            seven_rem_r  <= seven_rem_s;
            large_rem_r  <= large_rem_s;
            deck_cnt_r   <= deck_cnt_s;
            retry_r      <= retry_s;
            last_cat_r   <= last_cat_s;
            last_valid_r <= last_valid_s;
            deck_add_r   <= deck_add_s;
            small_add_r  <= small_add_s;
            seven_add_r  <= seven_add_s;
            large_add_r  <= large_add_s;
            back_r       <= back_s;
            busy_r       <= busy_s;
            empty_r      <= empty_s;
            remaining_r  <= remaining_s;
        end
    end

    assign deck_add  = deck_add_r;
    assign small_add = small_add_r;
    assign seven_add = seven_add_r;
    assign large_add = large_add_r;
    assign back      = back_r;
    assign busy      = busy_r;
    assign empty     = empty_r;
    assign remaining = remaining_r;

endmodule

// File: tb/tb_blackjack_shoe_dealer.sv
// -----------------------------------------------------------------------------
// tb_blackjack_shoe_dealer
//   Directed scenarios followed by random stimulus. A behavioural shoe model
//   (integer pools, arithmetic LFSR, modulo-based card pick) predicts every
//   output after every clock edge.
// -----------------------------------------------------------------------------
module tb_blackjack_shoe_dealer;

    localparam int          MAXD   = 8;
    localparam logic [15:0] SEED_A = 16'hACE1;
    localparam logic [15:0] SEED_B = 16'h5A5A;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_DEAL  = 2;
    localparam int M_DRAW  = 3;
    localparam int M_EMPTY = 4;

    logic        clk = 1'b0;
    logic        rst, start, deal_req, undo;
    logic [7:0]  num_decks;
    logic        deck_add, small_add, seven_add, large_add, back, busy, empty;
    logic [15:0] remaining;
    logic        b_deck_add, b_small_add, b_seven_add, b_large_add, b_back, b_busy, b_empty;
    logic [15:0] b_remaining;

    always #5 clk = ~clk;

    blackjack_shoe_dealer #(.MAX_DECKS(MAXD), .SEED(SEED_A)) dut (
        .clk(clk), .rst(rst), .start(start), .num_decks(num_decks),
        .deal_req(deal_req), .undo(undo),
        .deck_add(deck_add), .small_add(small_add), .seven_add(seven_add),
        .large_add(large_add), .back(back), .busy(busy), .empty(empty),
        .remaining(remaining)
    );

    blackjack_shoe_dealer #(.MAX_DECKS(MAXD), .SEED(SEED_B)) dut_b (
        .clk(clk), .rst(rst), .start(start), .num_decks(num_decks),
        .deal_req(deal_req), .undo(undo),
        .deck_add(b_deck_add), .small_add(b_small_add), .seven_add(b_seven_add),
        .large_add(b_large_add), .back(b_back), .busy(b_busy), .empty(b_empty),
        .remaining(b_remaining)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- behavioural shoe model ----------------
    int m_mode;
    int m_pool[3];
    int m_lfsr;
    int m_decks_left;
    int m_tries;
    int m_last;
    bit m_have_last;
    int e_deck, e_card[3], e_back, e_busy, e_empty, e_rem;

    function automatic int lfsr_next(input int v);
        return (v / 2) ^ (((v % 2) == 1) ? 32'hB400 : 0);
    endfunction

    task automatic model_step(input bit r, input bit s, input int nd, input bit q, input bit u);
        int cur, total, p, pick, cat, eff;
        bit got;
        e_deck = 0; e_back = 0;
        for (int k = 0; k < 3; k++) e_card[k] = 0;
        if (r) begin
            m_mode = M_IDLE; m_lfsr = SEED_A; m_decks_left = 0; m_tries = 0;
            m_last = 0; m_have_last = 0;
            for (int k = 0; k < 3; k++) m_pool[k] = 0;
        end else begin
            cur    = m_lfsr;
            m_lfsr = lfsr_next(cur);
            total  = m_pool[0] + m_pool[1] + m_pool[2];
            if (s) begin
                eff = (nd > MAXD) ? MAXD : nd;
                m_pool[0] = 20 * eff; m_pool[1] = 12 * eff; m_pool[2] = 20 * eff;
                m_have_last = 0; m_tries = 0; m_decks_left = eff;
                m_mode = (eff == 0) ? M_EMPTY : M_LOAD;
            end else if (m_mode == M_LOAD) begin
                e_deck = 1;
                m_decks_left--;
                if (m_decks_left == 0) m_mode = M_DEAL;
            end else if (m_mode == M_DEAL) begin
                if (total == 0) m_mode = M_EMPTY;
                else if (u && m_have_last) begin
                    m_pool[m_last]++; m_have_last = 0; e_back = 1;
                end else if (q) m_mode = M_DRAW;
            end else if (m_mode == M_DRAW) begin
                p = 1;
                while (p < total) p = p * 2;
                pick = cur % p;
                got = 0; cat = 0;
                if (pick < total) begin
                    got = 1;
                    cat = (pick < m_pool[0]) ? 0 : (pick < m_pool[0] + m_pool[1]) ? 1 : 2;
                end else if (m_tries == 15) begin
                    got = 1;
                    cat = (m_pool[2] > 0) ? 2 : (m_pool[1] > 0) ? 1 : 0;
                end else begin
                    m_tries++;
                end
                if (got) begin
                    e_card[cat] = 1; m_pool[cat]--; m_last = cat;
                    m_have_last = 1; m_tries = 0; m_mode = M_DEAL;
                end
            end else if (m_mode == M_EMPTY) begin
                if (u && m_have_last) begin
                    m_pool[m_last]++; m_have_last = 0; e_back = 1; m_mode = M_DEAL;
                end
            end
        end
        e_busy  = (m_mode == M_LOAD || m_mode == M_DRAW) ? 1 : 0;
        e_empty = (m_mode == M_EMPTY) ? 1 : 0;
        e_rem   = m_pool[0] + m_pool[1] + m_pool[2];
    endtask

    // ---------------- tallies and recorders ----------------
    int cnt_deck, cnt_card[3], cnt_back;
    int dut_last_cat;
    bit rec_en;
    int seq_a[$], seq_b[$];

    task automatic clear_tallies();
        cnt_deck = 0; cnt_back = 0;
        for (int k = 0; k < 3; k++) cnt_card[k] = 0;
    endtask

    task automatic cycle(input bit r, input bit s, input int nd, input bit q, input bit u);
        rst = r; start = s; num_decks = nd[7:0]; deal_req = q; undo = u;
        model_step(r, s, nd, q, u);
        @(posedge clk);
        #1;
        check("deck_add",  int'(deck_add),  e_deck);
        check("small_add", int'(small_add), e_card[0]);
        check("seven_add", int'(seven_add), e_card[1]);
        check("large_add", int'(large_add), e_card[2]);
        check("back",      int'(back),      e_back);
        check("busy",      int'(busy),      e_busy);
        check("empty",     int'(empty),     e_empty);
        check("remaining", int'(remaining), e_rem);
        check("one_event", int'($countones({deck_add, small_add, seven_add, large_add, back}) <= 1), 1);
        cnt_deck += int'(deck_add);
        cnt_back += int'(back);
        cnt_card[0] += int'(small_add);
        cnt_card[1] += int'(seven_add);
        cnt_card[2] += int'(large_add);
        if (small_add) dut_last_cat = 0;
        if (seven_add) dut_last_cat = 1;
        if (large_add) dut_last_cat = 2;
        if (rec_en) begin
            if (small_add) seq_a.push_back(0);
            if (seven_add) seq_a.push_back(1);
            if (large_add) seq_a.push_back(2);
            if (b_small_add) seq_b.push_back(0);
            if (b_seven_add) seq_b.push_back(1);
            if (b_large_add) seq_b.push_back(2);
        end
    endtask

    // Hold deal_req until the model reports a dealt card.
    task automatic deal_one(input string tag);
        bit seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cycle(0, 0, 0, 1, 0);
            seen = (e_card[0] + e_card[1] + e_card[2]) != 0;
        end
        check(tag, int'(seen), 1);
    endtask

    task automatic deal_until_empty(input string tag);
        bit done = 0;
        for (int i = 0; i < 1200 && !done; i++) begin
            cycle(0, 0, 0, 1, 0);
            done = (m_mode == M_EMPTY);
        end
        check(tag, int'(done), 1);
    endtask

    int seq1[$], seq2[$], seqb1[$];
    int same_cat;

    initial begin
        rec_en = 0; dut_last_cat = -1;
        clear_tallies();
        cycle(1, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);

        // Single deck, dealt to exhaustion.
        cycle(0, 1, 1, 0, 0);
        clear_tallies();
        deal_until_empty("t1_reach_empty");
        check("t1_decks", cnt_deck, 1);
        check("t1_small", cnt_card[0], 20);
        check("t1_seven", cnt_card[1], 12);
        check("t1_large", cnt_card[2], 20);
        check("t1_empty", int'(empty), 1);
        check("t1_rem0",  int'(remaining), 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 1, 0);
        check("t1_no_more", cnt_card[0] + cnt_card[1] + cnt_card[2], 52);

        // Zero decks and clamped deck count.
        clear_tallies();
        cycle(0, 1, 0, 0, 0);
        check("t2_zero_empty", int'(empty), 1);
        cycle(0, 1, 20, 0, 0);
        for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 0);
        check("t2_clamp_decks", cnt_deck, 8);
        check("t2_clamp_rem", int'(remaining), 416);

        // Undo behaviour.
        cycle(0, 1, 1, 0, 0);
        deal_one("t3_first_card");
        cycle(0, 0, 0, 0, 1);
        check("t3_back", int'(back), 1);
        check("t3_rem_restored", int'(remaining), 52);
        cycle(0, 0, 0, 0, 1);
        check("t3_second_undo", int'(back), 0);
        deal_one("t3_card2");
        cycle(0, 0, 0, 1, 1);
        check("t3_undo_wins", int'(back), 1);
        cycle(0, 0, 0, 1, 0);
        deal_one("t3_held_req_deals");
        check("t3_rem_after", int'(remaining), 51);

        // Exhaust, undo from EMPTY, re-deal the same category.
        deal_until_empty("t4_reach_empty");
        same_cat = m_last;
        cycle(0, 0, 0, 0, 1);
        check("t4_back", int'(back), 1);
        check("t4_rem1", int'(remaining), 1);
        check("t4_not_empty", int'(empty), 0);
        deal_one("t4_redeal");
        check("t4_same_cat", dut_last_cat, same_cat);

        // Reproducibility and seed sensitivity.
        for (int run = 0; run < 2; run++) begin
            seq_a.delete(); seq_b.delete();
            cycle(1, 0, 0, 0, 0);
            rec_en = 1;
            cycle(0, 1, 1, 0, 0);
            for (int i = 0; i < 250; i++) cycle(0, 0, 0, 1, 0);
            rec_en = 0;
            if (run == 0) begin
                seq1 = seq_a; seqb1 = seq_b;
            end else begin
                seq2 = seq_a;
            end
        end
        check("t5_len", int'(seq1.size() >= 10 && seq2.size() >= 10 && seqb1.size() >= 10), 1);
        if (seq1.size() >= 10 && seq2.size() >= 10 && seqb1.size() >= 10) begin
            bit same_run = 1, same_seed = 1;
            for (int i = 0; i < 10; i++) begin
                if (seq1[i] != seq2[i])  same_run  = 0;
                if (seq1[i] != seqb1[i]) same_seed = 0;
            end
            check("t5_repro", int'(same_run), 1);
            check("t5_seed_differs", int'(same_seed), 0);
        end

        // start during a draw aborts it.
        cycle(0, 1, 1, 0, 0);
        for (int i = 0; i < 20 && m_mode != M_DRAW; i++) cycle(0, 0, 0, 1, 0);
        check("t6_in_draw", int'(busy), 1);
        clear_tallies();
        cycle(0, 1, 2, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0);
        check("t6_no_card", cnt_card[0] + cnt_card[1] + cnt_card[2], 0);
        check("t6_decks", cnt_deck, 2);
        check("t6_rem", int'(remaining), 104);

        // Reset in the middle of loading.
        cycle(0, 1, 8, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0);
        cycle(1, 0, 0, 0, 0);
        check("t7_outputs_zero",
              int'({deck_add, small_add, seven_add, large_add, back, busy, empty} != 7'd0) + int'(remaining), 0);

        // Random traffic.
        cycle(0, 1, 3, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            bit r, s, q, u;
            int nd;
            r  = ($urandom_range(0, 999) == 0);
            s  = ($urandom_range(0, 199) == 0);
            nd = $urandom_range(0, 12);
            q  = ($urandom_range(0, 9) < 7);
            u  = ($urandom_range(0, 19) == 0);
            cycle(r, s, nd, q, u);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
